// File: rtl/nn_pkg.sv
// Shared types, defaults and saturation helper for the argmax output layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_pkg;

    localparam int N_IN_DEF   = 62;
    localparam int N_OUT_DEF  = 10;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        LAST,
        CMP,
        DONE
    } state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    // The caller truncates the result to w bits; the value always fits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            sat = hi;
        else if (x < lo)
            sat = lo;
        else
            sat = x;
    endfunction

endpackage

// File: rtl/nn_layer_argmax_if.sv
// Control, memory-port and result bundle of the argmax output layer.
// Latency: n/a (wiring only); memory data returns one cycle after its address.
// Backpressure: none; start is a request that is only honoured while ready is high.
interface nn_layer_argmax_if
    import nn_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    localparam int XW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN * N_OUT);
    localparam int JW = $clog2(N_OUT);

    logic                     start;
    logic                     ready;
    logic                     done;
    logic [XW-1:0]            x_addr;
    logic signed [DATA_W-1:0] x_data;
    logic [WW-1:0]            w_addr;
    logic signed [DATA_W-1:0] w_data;
    logic [JW-1:0]            b_addr;
    logic signed [DATA_W-1:0] b_data;
    logic [JW-1:0]            max_index;
    logic signed [ACC_W-1:0]  max_value;

    modport master (
        output start, x_data, w_data, b_data,
        input  ready, done, x_addr, w_addr, b_addr, max_index, max_value
    );

    modport slave (
        input  start, x_data, w_data, b_data,
        output ready, done, x_addr, w_addr, b_addr, max_index, max_value
    );

endinterface

// File: rtl/nn_mac_sat.sv
// Signed multiply-accumulate with saturation; clear, bias load or product accumulate.
// Latency: 1 cycle (result visible the cycle after the control strobe).
// Backpressure: none; controls are strobes, accumulator holds when all are low.
module nn_mac_sat
    import nn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     load,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [63:0]         sum;

    // Product and saturated sum; clear beats load beats accumulate.
    always_comb begin
        prod  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        sum   = 64'(acc_q) + 64'(prod);
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (load)
            acc_d = ACC_W'(bias);
        else if (acc_en)
            acc_d = ACC_W'(sat(sum, ACC_W));
    end

    // Accumulator register with synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/nn_layer_argmax.sv
// Time-multiplexed FC output layer with argmax; one shared MAC walks N_OUT neurons.
// Latency: N_OUT*(N_IN+3)+1 cycles from the start-sampling edge to the done pulse.
// Backpressure: none; start is ignored unless ready (IDLE), results hold until next done.
module nn_layer_argmax
    import nn_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter bit RELU_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    nn_layer_argmax_if.slave bus
);
    localparam int XW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN * N_OUT);
    localparam int JW = $clog2(N_OUT);

    localparam logic [XW-1:0]        I_LAST  = XW'(N_IN - 1);
    localparam logic [JW-1:0]        J_LAST  = JW'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [JW-1:0]           j_q, j_d;
    logic [XW-1:0]           x_addr_q, x_addr_d;
    logic [WW-1:0]           w_addr_q, w_addr_d;
    logic [JW-1:0]           b_addr_q, b_addr_d;
    logic signed [ACC_W-1:0] run_max_q, run_max_d;
    logic [JW-1:0]           run_idx_q, run_idx_d;
    logic [JW-1:0]           max_index_q, max_index_d;
    logic signed [ACC_W-1:0] max_value_q, max_value_d;

    logic                    mac_clr, mac_load, mac_acc;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] v;
    logic                    upd;

    nn_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mac_clr),
        .load   (mac_load),
        .acc_en (mac_acc),
        .a      (bus.x_data),
        .b      (bus.w_data),
        .bias   (bus.b_data),
        .acc    (acc)
    );

    // Sequencing, address generation and running argmax. Addresses are set on
    // the edge entering their state so memory data lines up one cycle later.
    // The final result is captured on the edge into DONE so it is valid with done.
    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        x_addr_d    = x_addr_q;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        max_index_d = max_index_q;
        max_value_d = max_value_q;
        mac_clr     = 1'b0;
        mac_load    = 1'b0;
        mac_acc     = 1'b0;
        v           = (RELU_EN && acc < 0) ? '0 : acc;
        // Strictly greater keeps the lowest index on ties.
        upd         = (j_q == '0) || (v > run_max_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = BIAS;
                    j_d       = '0;
                    run_max_d = ACC_MIN;
                    run_idx_d = '0;
                    b_addr_d  = '0;
                    mac_clr   = 1'b1;
                end
            end
            BIAS: begin
                state_d  = MAC;
                x_addr_d = '0;
                w_addr_d = WW'(int'(j_q) * N_IN);
            end
            MAC: begin
                // Element 0 slot loads the bias; later slots add element i-1.
                if (x_addr_q == '0)
                    mac_load = 1'b1;
                else
                    mac_acc = 1'b1;
                if (x_addr_q == I_LAST) begin
                    state_d = LAST;
                end else begin
                    x_addr_d = x_addr_q + 1'b1;
                    w_addr_d = w_addr_q + 1'b1;
                end
            end
            LAST: begin
                mac_acc = 1'b1;
                state_d = CMP;
            end
            CMP: begin
                if (upd) begin
                    run_max_d = v;
                    run_idx_d = j_q;
                end
                if (j_q == J_LAST) begin
                    state_d     = DONE;
                    max_index_d = upd ? j_q : run_idx_q;
                    max_value_d = upd ? v : run_max_q;
                end else begin
                    state_d  = BIAS;
                    j_d      = j_q + 1'b1;
                    b_addr_d = j_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronously cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            j_q         <= '0;
            x_addr_q    <= '0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            max_index_q <= '0;
            max_value_q <= '0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            x_addr_q    <= x_addr_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            max_index_q <= max_index_d;
            max_value_q <= max_value_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.x_addr    = x_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.max_index = max_index_q;
    assign bus.max_value = max_value_q;

endmodule

// File: tb/tb_nn_layer_argmax.sv
// Directed bench for nn_layer_argmax over four configurations sharing one memory image.
module tb_nn_layer_argmax;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Shared synchronous-read memory image, sized for the largest configuration.
    logic signed [7:0] mx [0:61];
    logic signed [7:0] mw [0:619];
    logic signed [7:0] mb [0:9];

    // Configurations: A relu, B no relu, C 16-bit acc no relu, D default.
    int n_in_c  [4] = '{4, 4, 4, 62};
    int n_out_c [4] = '{3, 3, 3, 10};
    int accw_c  [4] = '{24, 24, 16, 24};
    int relu_c  [4] = '{1, 0, 0, 1};

    nn_layer_argmax_if #(.N_IN(4),  .N_OUT(3),  .DATA_W(8), .ACC_W(24)) ifa ();
    nn_layer_argmax_if #(.N_IN(4),  .N_OUT(3),  .DATA_W(8), .ACC_W(24)) ifb ();
    nn_layer_argmax_if #(.N_IN(4),  .N_OUT(3),  .DATA_W(8), .ACC_W(16)) ifc ();
    nn_layer_argmax_if #(.N_IN(62), .N_OUT(10), .DATA_W(8), .ACC_W(24)) ifd ();

    nn_layer_argmax #(.N_IN(4),  .N_OUT(3),  .DATA_W(8), .ACC_W(24), .RELU_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    nn_layer_argmax #(.N_IN(4),  .N_OUT(3),  .DATA_W(8), .ACC_W(24), .RELU_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    nn_layer_argmax #(.N_IN(4),  .N_OUT(3),  .DATA_W(8), .ACC_W(16), .RELU_EN(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    nn_layer_argmax #(.N_IN(62), .N_OUT(10), .DATA_W(8), .ACC_W(24), .RELU_EN(1'b1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

    always @(posedge clk) begin
        ifa.x_data <= mx[ifa.x_addr]; ifa.w_data <= mw[ifa.w_addr]; ifa.b_data <= mb[ifa.b_addr];
        ifb.x_data <= mx[ifb.x_addr]; ifb.w_data <= mw[ifb.w_addr]; ifb.b_data <= mb[ifb.b_addr];
        ifc.x_data <= mx[ifc.x_addr]; ifc.w_data <= mw[ifc.w_addr]; ifc.b_data <= mb[ifc.b_addr];
        ifd.x_data <= mx[ifd.x_addr]; ifd.w_data <= mw[ifd.w_addr]; ifd.b_data <= mb[ifd.b_addr];
    end

    logic   start_v [4];
    logic   ready_v [4];
    logic   done_v  [4];
    int     idx_v   [4];
    longint val_v   [4];

    assign ifa.start = start_v[0];
    assign ifb.start = start_v[1];
    assign ifc.start = start_v[2];
    assign ifd.start = start_v[3];
    assign ready_v[0] = ifa.ready; assign done_v[0] = ifa.done;
    assign ready_v[1] = ifb.ready; assign done_v[1] = ifb.done;
    assign ready_v[2] = ifc.ready; assign done_v[2] = ifc.done;
    assign ready_v[3] = ifd.ready; assign done_v[3] = ifd.done;
    assign idx_v[0] = int'(ifa.max_index); assign val_v[0] = longint'(ifa.max_value);
    assign idx_v[1] = int'(ifb.max_index); assign val_v[1] = longint'(ifb.max_value);
    assign idx_v[2] = int'(ifc.max_index); assign val_v[2] = longint'(ifc.max_value);
    assign idx_v[3] = int'(ifd.max_index); assign val_v[3] = longint'(ifd.max_value);

    typedef struct {
        int     idx;
        longint val;
    } res_t;
    res_t sb [$];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint clampw(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    // Reference: bias, saturating per-element accumulate, optional ReLU, first-max argmax.
    task automatic model(input int k, output int ei, output longint ev);
        longint acc;
        longint v;
        ei = 0;
        ev = 0;
        for (int j = 0; j < n_out_c[k]; j++) begin
            acc = longint'(mb[j]);
            for (int i = 0; i < n_in_c[k]; i++)
                acc = clampw(acc + longint'(mx[i]) * longint'(mw[j*n_in_c[k] + i]), accw_c[k]);
            v = (relu_c[k] != 0 && acc < 0) ? 0 : acc;
            if (j == 0 || v > ev) begin
                ev = v;
                ei = j;
            end
        end
    endtask

    // One transaction: push expectation, pulse start, optionally pulse start again
    // in busy cycles pa/pb, and follow the run until the cycle after done.
    task automatic run(input int k, input int pa, input int pb, output int t0, output int dc);
        int     c;
        int     dones;
        int     ei;
        longint ev;
        bit     busy_ok;
        res_t   e;
        model(k, ei, ev);
        e.idx = ei;
        e.val = ev;
        sb.push_back(e);
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        t0 = cyc;
        c = 1;
        dc = 0;
        dones = 0;
        busy_ok = 1'b1;
        while (c <= 800) begin
            if (dc == 0 && ready_v[k]) busy_ok = 1'b0;
            if (done_v[k]) begin
                dones++;
                if (dc == 0) begin
                    dc = c;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("max_index", idx_v[k], e.idx);
                        check("max_value", val_v[k], e.val);
                    end else begin
                        check("scoreboard_depth", sb.size(), 1);
                    end
                end
            end
            if (dc != 0 && c == dc + 1) break;
            start_v[k] = (c == pa || c == pb);
            @(posedge clk); #1;
            c++;
        end
        start_v[k] = 1'b0;
        if (dc == 0) sb.delete();
        check("done_cycle", dc, n_out_c[k] * (n_in_c[k] + 3) + 1);
        check("done_once", dones, 1);
        check("ready_low_while_busy", busy_ok, 1);
        check("ready_after_done", ready_v[k], 1);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 620; i++) mw[i] = 8'sd0;
        for (int i = 0; i < 62; i++) mx[i] = 8'sd0;
        for (int j = 0; j < 10; j++) mb[j] = 8'sd0;
        for (int i = 0; i < 4; i++) begin
            mx[i] = 8'(i + 1);
            mw[i] = 8'sd1;
        end
        mw[4]  = 8'sd2;
        mw[11] = 8'sd3;
    endtask

    int t0a, dca, t0b, dcb, dn;

    initial begin
        for (int k = 0; k < 4; k++) start_v[k] = 1'b0;
        rst_n = 1'b0;
        load_basic();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_ready", ready_v[0], 1);
        check("rst_done", done_v[0], 0);
        check("rst_max_index", idx_v[0], 0);
        check("rst_max_value", val_v[0], 0);
        check("rst_x_addr", ifa.x_addr, 0);
        check("rst_w_addr", ifa.w_addr, 0);

        // Basic scores 10,2,12 with busy start pulses, then a back-to-back run.
        run(0, 5, 21, t0a, dca);
        check("basic_index", idx_v[0], 2);
        check("basic_value", val_v[0], 12);
        run(0, 0, 0, t0b, dcb);
        check("b2b_done_cycle", t0b - t0a + dcb, 45);

        // All-negative sums clamp to zero; tie resolves to index 0.
        for (int i = 0; i < 12; i++) mw[i] = 8'(-(1 + i % 3));
        for (int j = 0; j < 3; j++) mb[j] = -8'sd5;
        run(0, 0, 0, t0a, dca);
        check("relu_tie_index", idx_v[0], 0);
        check("relu_tie_value", val_v[0], 0);

        // Reset in cycle 10 of a run: back to idle with cleared results, no done.
        load_basic();
        run(0, 0, 0, t0a, dca);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_ready", ready_v[0], 1);
        check("midrst_max_index", idx_v[0], 0);
        check("midrst_max_value", val_v[0], 0);
        check("midrst_done", done_v[0], 0);
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_v[0]) dn++;
        end
        check("midrst_no_done", dn, 0);
        run(0, 0, 0, t0a, dca);
        check("after_rst_index", idx_v[0], 2);
        check("after_rst_value", val_v[0], 12);

        // No ReLU: negative scores compared directly, tie -3/-3 keeps index 1.
        for (int i = 0; i < 12; i++) mw[i] = 8'sd0;
        mb[0] = -8'sd5; mb[1] = -8'sd3; mb[2] = -8'sd3;
        run(1, 0, 0, t0a, dca);
        check("norelu_index", idx_v[1], 1);
        check("norelu_value", val_v[1], -3);

        // 16-bit accumulator saturation in both directions.
        for (int i = 0; i < 4; i++) mx[i] = 8'sd127;
        for (int i = 0; i < 12; i++) mw[i] = 8'sd127;
        for (int j = 0; j < 3; j++) mb[j] = 8'sd127;
        run(2, 0, 0, t0a, dca);
        check("sat_pos_value", val_v[2], 32767);
        for (int i = 0; i < 4; i++) mx[i] = -8'sd128;
        run(2, 0, 0, t0a, dca);
        check("sat_neg_index", idx_v[2], 0);
        check("sat_neg_value", val_v[2], -32768);

        // Default configuration: random vectors against the model.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 62; i++) mx[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 620; i++) mw[i] = 8'($urandom_range(0, 255));
            for (int j = 0; j < 10; j++) mb[j] = 8'($urandom_range(0, 255));
            run(3, 0, 0, t0a, dca);
        end
        // Default configuration tie: biases only, maximum 9 at indices 1 and 3.
        for (int i = 0; i < 620; i++) mw[i] = 8'sd0;
        for (int j = 0; j < 10; j++) mb[j] = 8'(j % 3);
        mb[1] = 8'sd9;
        mb[3] = 8'sd9;
        run(3, 0, 0, t0a, dca);
        check("dflt_tie_index", idx_v[3], 1);
        check("dflt_tie_value", val_v[3], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
